// File: rtl/cpu_wb_arb.sv
// Writeback arbiter: ALU and long-latency results onto one register-file write port, plus pending-write scoreboard.
// Latency: ALU 1 cycle; long-latency 2 cycles minimum through a 2-entry FIFO, +1 per cycle the ALU holds the port.
// Backpressure: ALU never stalls; lu_ready drops when the FIFO holds two entries (no push-through on a full pop).

module wb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_vld,
    output logic         push_rdy,
    input  logic [W-1:0] push_dat,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    // Readiness looks only at the current count, so a full FIFO refuses even while popping.
    assign push_rdy = !reset && (cnt != FULL);
    assign pop_vld  = (cnt != '0);
    assign pop_dat  = mem[rd_ptr];
    assign do_push  = push_vld && push_rdy;
    assign do_pop   = pop_vld && pop_rdy;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

module cpu_wb_arb #(
    parameter int XLEN          = 32,
    parameter int GREGIDX_WIDTH = 5,
    parameter int GREG_COUNT    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid,
    input  logic [GREGIDX_WIDTH-1:0] alu_rd_idx,
    input  logic [XLEN-1:0]          alu_dat,
    input  logic                     lu_valid,
    output logic                     lu_ready,
    input  logic [GREGIDX_WIDTH-1:0] lu_rd_idx,
    input  logic [XLEN-1:0]          lu_dat,
    input  logic                     issue_valid,
    input  logic [GREGIDX_WIDTH-1:0] issue_rd_idx,
    input  logic [GREGIDX_WIDTH-1:0] q_rs1_idx,
    input  logic [GREGIDX_WIDTH-1:0] q_rs2_idx,
    output logic                     rs1_busy,
    output logic                     rs2_busy,
    output logic                     rd_wen,
    output logic [GREGIDX_WIDTH-1:0] rd_idx,
    output logic [XLEN-1:0]          rd_dat
);
    typedef struct packed {
        logic [GREGIDX_WIDTH-1:0] idx;
        logic [XLEN-1:0]          dat;
    } wb_ent_t;

    wb_ent_t               lu_ent;
    wb_ent_t               head;
    logic                  head_vld;
    logic                  rd_from_lu;
    logic [GREG_COUNT-1:0] sb;
    logic [GREG_COUNT-1:0] sb_nxt;

    assign lu_ent.idx = lu_rd_idx;
    assign lu_ent.dat = lu_dat;

    // The FIFO only drains on cycles the ALU leaves the write port free.
    wb_fifo #(
        .W     ($bits(wb_ent_t)),
        .DEPTH (2)
    ) u_lu_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (lu_valid),
        .push_rdy (lu_ready),
        .push_dat (lu_ent),
        .pop_vld  (head_vld),
        .pop_rdy  (!alu_valid),
        .pop_dat  (head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_wen     <= 1'b0;
            rd_idx     <= '0;
            rd_dat     <= '0;
            rd_from_lu <= 1'b0;
        end else if (alu_valid) begin
            rd_wen     <= (alu_rd_idx != '0);
            rd_idx     <= alu_rd_idx;
            rd_dat     <= alu_dat;
            rd_from_lu <= 1'b0;
        end else if (head_vld) begin
            rd_wen     <= (head.idx != '0);
            rd_idx     <= head.idx;
            rd_dat     <= head.dat;
            rd_from_lu <= 1'b1;
        end else begin
            rd_wen     <= 1'b0;
            rd_idx     <= '0;
            rd_dat     <= '0;
            rd_from_lu <= 1'b0;
        end
    end

    // Clear is applied before set so a same-edge issue to the retiring index stays pending.
    always_comb begin
        sb_nxt = sb;
        if (rd_wen && rd_from_lu) begin
            sb_nxt[rd_idx] = 1'b0;
        end
        if (issue_valid && (issue_rd_idx != '0)) begin
            sb_nxt[issue_rd_idx] = 1'b1;
        end
        sb_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sb <= '0;
        end else begin
            sb <= sb_nxt;
        end
    end

    assign rs1_busy = sb[q_rs1_idx];
    assign rs2_busy = sb[q_rs2_idx];
endmodule

// File: tb/tb_cpu_wb_arb.sv
// Directed bench for cpu_wb_arb: queue/array reference model checked every cycle, plus literal spot checks.
module tb_cpu_wb_arb;
    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd_idx;
    logic [31:0] alu_dat;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_rd_idx;
    logic [31:0] lu_dat;
    logic        issue_valid;
    logic [4:0]  issue_rd_idx;
    logic [4:0]  q_rs1_idx;
    logic [4:0]  q_rs2_idx;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rd_wen;
    logic [4:0]  rd_idx;
    logic [31:0] rd_dat;

    int n_cmp = 0;
    int n_err = 0;

    cpu_wb_arb #(.XLEN(32), .GREGIDX_WIDTH(5), .GREG_COUNT(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .alu_rd_idx   (alu_rd_idx),
        .alu_dat      (alu_dat),
        .lu_valid     (lu_valid),
        .lu_ready     (lu_ready),
        .lu_rd_idx    (lu_rd_idx),
        .lu_dat       (lu_dat),
        .issue_valid  (issue_valid),
        .issue_rd_idx (issue_rd_idx),
        .q_rs1_idx    (q_rs1_idx),
        .q_rs2_idx    (q_rs2_idx),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy),
        .rd_wen       (rd_wen),
        .rd_idx       (rd_idx),
        .rd_dat       (rd_dat)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: pending results queue, pending-register set, and the write the port shows now.
    typedef struct {
        logic [4:0]  idx;
        logic [31:0] dat;
    } ent_t;
    ent_t        mq[$];
    bit          msb[32];
    bit          m_wen     = 1'b0;
    logic [4:0]  m_idx     = '0;
    logic [31:0] m_dat     = '0;
    bit          m_from_lu = 1'b0;

    always @(negedge clk) begin
        bit   acc;
        ent_t e;
        cmp("m_rd_wen",   {31'd0, rd_wen},   {31'd0, m_wen});
        cmp("m_rd_idx",   {27'd0, rd_idx},   {27'd0, m_idx});
        cmp("m_rd_dat",   rd_dat,            m_dat);
        cmp("m_lu_ready", {31'd0, lu_ready}, {31'd0, (!reset && mq.size() < 2)});
        cmp("m_rs1_busy", {31'd0, rs1_busy}, {31'd0, msb[q_rs1_idx]});
        cmp("m_rs2_busy", {31'd0, rs2_busy}, {31'd0, msb[q_rs2_idx]});
        if (reset) begin
            mq.delete();
            for (int i = 0; i < 32; i++) msb[i] = 1'b0;
            m_wen = 0; m_idx = '0; m_dat = '0; m_from_lu = 0;
        end else begin
            if (m_wen && m_from_lu) msb[m_idx] = 1'b0;
            if (issue_valid && issue_rd_idx != 0) msb[issue_rd_idx] = 1'b1;
            acc = lu_valid && (mq.size() < 2);
            if (alu_valid) begin
                m_wen = (alu_rd_idx != 0); m_idx = alu_rd_idx; m_dat = alu_dat; m_from_lu = 0;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                m_wen = (e.idx != 0); m_idx = e.idx; m_dat = e.dat; m_from_lu = 1;
            end else begin
                m_wen = 0; m_idx = '0; m_dat = '0; m_from_lu = 0;
            end
            if (acc) begin
                e.idx = lu_rd_idx;
                e.dat = lu_dat;
                mq.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 0; alu_rd_idx = '0; alu_dat = '0;
        lu_valid = 0; lu_rd_idx = '0; lu_dat = '0;
        issue_valid = 0; issue_rd_idx = '0;
    endtask

    task automatic alu(input logic [4:0] i, input logic [31:0] d);
        alu_valid = 1; alu_rd_idx = i; alu_dat = d;
    endtask

    task automatic lu(input logic [4:0] i, input logic [31:0] d);
        lu_valid = 1; lu_rd_idx = i; lu_dat = d;
    endtask

    task automatic issue(input logic [4:0] i);
        issue_valid = 1; issue_rd_idx = i;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle();
        q_rs1_idx = '0; q_rs2_idx = '0;
        reset = 1;
        alu(5'd5, 32'h1234_5678);
        @(negedge clk);
        cmp("rst_wen",    {31'd0, rd_wen},   32'd0);
        cmp("rst_ready",  {31'd0, lu_ready}, 32'd0);
        cmp("rst_dat",    rd_dat,            32'd0);
        tick();
        @(negedge clk);
        cmp("rst2_idx",   {27'd0, rd_idx},   32'd0);
        cmp("rst2_busy",  {31'd0, rs1_busy}, 32'd0);
        tick();

        // Release; first ALU write, then a write to x0.
        reset = 0; idle();
        alu(5'd5, 32'hDEAD_BEEF);
        @(negedge clk);
        cmp("rel_ready",  {31'd0, lu_ready}, 32'd1);
        cmp("rel_wen",    {31'd0, rd_wen},   32'd0);
        tick();
        alu(5'd0, 32'h0000_0055);
        @(negedge clk);
        cmp("alu_wen",    {31'd0, rd_wen},   32'd1);
        cmp("alu_idx",    {27'd0, rd_idx},   32'd5);
        cmp("alu_dat",    rd_dat,            32'hDEAD_BEEF);
        tick();
        idle();
        @(negedge clk);
        cmp("alu0_wen",   {31'd0, rd_wen},   32'd0);
        tick();

        // Priority and backpressure: ALU held four cycles while three long results arrive.
        alu(5'd10, 32'hA0); lu(5'd3, 32'h11);
        @(negedge clk); cmp("pri_c0_ready", {31'd0, lu_ready}, 32'd1);
        tick();
        alu(5'd11, 32'hA1); lu(5'd4, 32'h22);
        @(negedge clk); cmp("pri_c1_idx", {27'd0, rd_idx}, 32'd10);
        tick();
        alu(5'd12, 32'hA2); lu(5'd6, 32'h33);
        @(negedge clk); cmp("pri_c2_ready", {31'd0, lu_ready}, 32'd0);
        tick();
        alu(5'd13, 32'hA3);
        @(negedge clk); cmp("pri_c3_ready", {31'd0, lu_ready}, 32'd0);
        tick();
        alu_valid = 0;
        @(negedge clk);
        cmp("pri_c4_idx",   {27'd0, rd_idx},   32'd13);
        cmp("pri_c4_ready", {31'd0, lu_ready}, 32'd0);
        tick();
        @(negedge clk);
        cmp("pri_c5_idx",   {27'd0, rd_idx},   32'd3);
        cmp("pri_c5_dat",   rd_dat,            32'h11);
        cmp("pri_c5_ready", {31'd0, lu_ready}, 32'd1);
        tick();
        idle();
        @(negedge clk); cmp("pri_c6_idx", {27'd0, rd_idx}, 32'd4);
        tick();
        @(negedge clk);
        cmp("pri_c7_idx", {27'd0, rd_idx}, 32'd6);
        cmp("pri_c7_dat", rd_dat,          32'h33);
        tick();
        @(negedge clk); cmp("pri_c8_wen", {31'd0, rd_wen}, 32'd0);
        tick();

        // Scoreboard set, hold through writeback, clear; x0 never busy.
        q_rs1_idx = 5'd7; q_rs2_idx = 5'd0;
        issue(5'd7);
        @(negedge clk); cmp("sb_c0_busy", {31'd0, rs1_busy}, 32'd0);
        tick();
        idle(); issue(5'd0); lu(5'd7, 32'h77);
        @(negedge clk); cmp("sb_c1_busy", {31'd0, rs1_busy}, 32'd1);
        tick();
        idle();
        @(negedge clk);
        cmp("sb_c2_busy",  {31'd0, rs1_busy}, 32'd1);
        cmp("sb_c2_busy0", {31'd0, rs2_busy}, 32'd0);
        tick();
        @(negedge clk);
        cmp("sb_c3_busy", {31'd0, rs1_busy}, 32'd1);
        cmp("sb_c3_idx",  {27'd0, rd_idx},   32'd7);
        tick();
        @(negedge clk); cmp("sb_c4_busy", {31'd0, rs1_busy}, 32'd0);
        tick();

        // Set/clear collision on x9.
        q_rs1_idx = 5'd9;
        issue(5'd9);
        tick();
        idle(); lu(5'd9, 32'h99);
        tick();
        idle();
        tick();
        issue(5'd9);
        @(negedge clk); cmp("col_idx", {27'd0, rd_idx}, 32'd9);
        tick();
        idle();
        @(negedge clk); cmp("col_busy", {31'd0, rs1_busy}, 32'd1);
        tick();

        // Reset with two queued results and x3/x4 pending.
        q_rs1_idx = 5'd3; q_rs2_idx = 5'd4;
        alu(5'd1, 32'hB0); issue(5'd3);
        tick();
        alu(5'd1, 32'hB1); issue(5'd4); lu(5'd3, 32'h333);
        tick();
        alu(5'd1, 32'hB2); issue_valid = 0; lu(5'd4, 32'h444);
        tick();
        lu_valid = 0;
        @(negedge clk);
        cmp("mr_busy3",  {31'd0, rs1_busy}, 32'd1);
        cmp("mr_busy4",  {31'd0, rs2_busy}, 32'd1);
        cmp("mr_ready",  {31'd0, lu_ready}, 32'd0);
        tick();
        idle(); reset = 1;
        tick();
        tick();
        reset = 0;
        @(negedge clk);
        cmp("mr_post_busy3", {31'd0, rs1_busy}, 32'd0);
        cmp("mr_post_busy4", {31'd0, rs2_busy}, 32'd0);
        cmp("mr_post_ready", {31'd0, lu_ready}, 32'd1);
        tick();
        @(negedge clk); cmp("mr_post_wen1", {31'd0, rd_wen}, 32'd0);
        tick();
        @(negedge clk); cmp("mr_post_wen2", {31'd0, rd_wen}, 32'd0);
        tick();

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
